alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised, registered successor of the single-cycle ALU for the MIPS datapath.
//  Same 4-bit option encoding, but WIDTH-generic, with valid/ready handshakes in and out.
//  Iterative MUL/DIV (one bit per cycle) replace the combinational * and /, adding a hi word and a div-by-zero flag.
//  Sits between the ID/EX operand latch and the EX/MEM stage; the pipeline stalls while in_ready=0.
// PARAMETERS
//  WIDTH      32  operand/result width in bits (>=8, power of 2)
//  SHAMT_W    5   shift-amount bits taken from operand LSBs (= log2(WIDTH))
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        oprd1/oprd2/option valid this cycle
//  in_ready     out  1        block can accept a new operation
//  oprd1        in   WIDTH    operand A
//  oprd2        in   WIDTH    operand B
//  option       in   4        operation code (table below)
//  out_valid    out  1        result/zero/hi/div0 valid
//  out_ready    in   1        consumer takes result this cycle
//  result       out  WIDTH    primary result (low product / quotient)
//  hi           out  WIDTH    high product (MUL) / remainder (DIV), 0 otherwise
//  zero         out  1        result == 0
//  div0         out  1        DIV with oprd2 == 0
// BEHAVIOUR
//  Opcodes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL (oprd2<<oprd1[SHAMT_W-1:0]),
//   5 SRL (oprd2>>oprd1[..]), 6 SUB, 7 SLT signed (1/0), 8 MUL unsigned, 9 DIV unsigned,
//   A SRA ($signed(oprd1)>>>oprd2[..]), B reserved ->0, C NOR, D LUI (oprd2<<16, WIDTH>=32 else 0),
//   E EQ (1 if oprd1==oprd2), F MOVE (oprd1). ADD/SUB wrap mod 2^WIDTH, no overflow flag.
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, hi=0, zero=0, div0=0; any
//   in-flight MUL/DIV discarded. Reset asserted mid-operation aborts it; no output follows.
//  FSM: IDLE -> (accept, single-cycle op) -> DONE; IDLE -> (accept, op 8/9) -> BUSY;
//   BUSY -> DONE after exactly WIDTH iteration cycles; DONE -> IDLE when out_ready=1.
//  Accept = in_valid & in_ready; in_ready = (state==IDLE). Operands captured on accept;
//   later changes to input ports are ignored.
//  Latency (accept edge N): single-cycle ops out_valid from N+1; MUL/DIV out_valid from N+1+WIDTH.
//  No accept while BUSY or DONE (no pipelining of a second op); max 1 op in flight.
//  DONE: result/hi/zero/div0 held stable and out_valid=1 until out_ready=1; out_valid drops
//   the following cycle, in_ready rises the same cycle. out_ready while not DONE: ignored.
//  MUL: shift-add, 2*WIDTH product; result=low half, hi=high half.
//  DIV: restoring, one quotient bit per cycle; result=quotient, hi=remainder.
//   oprd2==0: still takes WIDTH cycles; result={WIDTH{1'b1}}, hi=oprd1, div0=1.
//  zero computed from final result, registered with it. div0=0 for every non-DIV op.
//  Reserved/undefined option: result=0, hi=0, zero=1, 1-cycle latency.
// TESTING
//  Reset: rst_n=0 mid-MUL at cycle 10 -> out_valid=0, in_ready=1, result=0 next edge; no late output.
//  ADD 0xFFFFFFFF+1, out_ready=1 -> out_valid at N+1, result=0, zero=1, then in_ready=1.
//  MUL 0xFFFFFFFF*2 -> out_valid at N+33, result=0xFFFFFFFE, hi=0x00000001; in_ready=0 throughout.
//  DIV 100/7 then DIV 5/0 -> result=14, hi=2, div0=0; then result=0xFFFFFFFF, hi=5, div0=1.
//  Backpressure: SLT 0xFFFFFFFF,1 with out_ready=0 for 5 cycles -> result=1 held, in_valid ignored.
//  WIDTH=8 build: SRA 0x80>>>3 -> 0xF0; MUL 0x10*0x10 -> result=0x00, hi=0x01 at N+9.

Source files
------------

// File: rtl/alu_multicycle.sv
// Registered, WIDTH-generic MIPS ALU with valid/ready handshakes and iterative MUL/DIV.
// Single-cycle ops finish one cycle after accept, MUL/DIV WIDTH cycles later; result is held until out_ready.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] oprd1,
  input  logic [WIDTH-1:0] oprd2,
  input  logic [3:0]       option,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div0
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;      // multiplicand or divisor
  logic [WIDTH-1:0]   acc_q, acc_d;  // high product / partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;    // multiplier bits / quotient bits
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               div0_q, div0_d;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   step_acc, step_lo;

  always_comb begin
    alu_res = '0;
    unique case (option)
      4'h0: alu_res = oprd1 & oprd2;
      4'h1: alu_res = oprd1 | oprd2;
      4'h2: alu_res = oprd1 + oprd2;
      4'h3: alu_res = oprd1 ^ oprd2;
      4'h4: alu_res = oprd2 << oprd1[SHAMT_W-1:0];
      4'h5: alu_res = oprd2 >> oprd1[SHAMT_W-1:0];
      4'h6: alu_res = oprd1 - oprd2;
      4'h7: alu_res = WIDTH'($signed(oprd1) < $signed(oprd2));
      4'hA: alu_res = $signed(oprd1) >>> oprd2[SHAMT_W-1:0];
      4'hC: alu_res = ~(oprd1 | oprd2);
      4'hD: alu_res = (WIDTH >= 32) ? (oprd2 << 16) : '0;
      4'hE: alu_res = WIDTH'(oprd1 == oprd2);
      4'hF: alu_res = oprd1;
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m_q});
    div_diff  = div_shift[WIDTH-1:0] - m_q;
    if (is_div_q) begin
      step_acc = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    div0_d   = div0_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (option == 4'h8 || option == 4'h9) begin
            state_d  = BUSY;
            is_div_d = option[0];
            cnt_d    = '0;
            acc_d    = '0;
            m_d      = option[0] ? oprd2 : oprd1;
            lo_d     = option[0] ? oprd1 : oprd2;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            hi_d     = '0;
            zero_d   = (alu_res == '0);
            div0_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        // A zero divisor naturally yields all-ones quotient and remainder = dividend.
        if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = step_lo;
          hi_d     = step_acc;
          zero_d   = (step_lo == '0);
          div0_d   = is_div_q && (m_q == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      div0_q   <= div0_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32 and WIDTH=8.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] oprd1, oprd2, result, hi;
  logic [3:0]  option;
  logic        zero, div0;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  oprd1_8, oprd2_8, result8, hi8;
  logic [3:0]  option8;
  logic        zero8, div0_8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .oprd1(oprd1), .oprd2(oprd2), .option(option), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .hi(hi), .zero(zero), .div0(div0)
  );

  alu_multicycle #(.WIDTH(8), .SHAMT_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .oprd1(oprd1_8), .oprd2(oprd2_8), .option(option8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .hi(hi8), .zero(zero8), .div0(div0_8)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one op on the 32-bit DUT (caller sits just after an edge, DUT idle) and retire it.
  task automatic do32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] r, output logic [31:0] h, output logic z,
                      output logic dz, output int lat, output logic rdy_low);
    in_valid = 1'b1; option = op; oprd1 = a; oprd2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; oprd1 = $urandom; oprd2 = $urandom; option = 4'h2;
    lat = 0; rdy_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    r = result; h = hi; z = zero; dz = div0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] r, output logic [7:0] h, output int lat);
    in_valid8 = 1'b1; option8 = op; oprd1_8 = a; oprd2_8 = b;
    @(posedge clk); #1;
    in_valid8 = 1'b0; oprd1_8 = 8'hA5; oprd2_8 = 8'h5A;
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result8; h = hi8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  logic [3:0]  t_op  [13] = '{4'h0, 4'h1, 4'h3, 4'hC, 4'h6, 4'h4, 4'h5, 4'hA,
                              4'hD, 4'hE, 4'hE, 4'hF, 4'hB};
  logic [31:0] t_a   [13] = '{32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234,
                              32'd5, 32'h24, 32'd4, 32'h80000000, 32'd0, 32'd7,
                              32'd7, 32'hDEADBEEF, 32'h12345678};
  logic [31:0] t_b   [13] = '{32'h0FF05678, 32'h0FF05678, 32'h0FF05678, 32'h0FF05678,
                              32'd7, 32'h80000001, 32'h80000010, 32'h24, 32'h1234,
                              32'd7, 32'd8, 32'd3, 32'h9ABCDEF0};
  logic [31:0] t_exp [13] = '{32'h00F01230, 32'hFFF0567C, 32'hFF00444C, 32'h000FA983,
                              32'hFFFFFFFE, 32'h00000010, 32'h08000001, 32'hF8000000,
                              32'h12340000, 32'd1, 32'd0, 32'hDEADBEEF, 32'd0};

  initial begin
    logic [31:0] r, h;
    logic [7:0]  r8, h8;
    logic        z, dz, rl, ok;
    int          lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; oprd1 = '0; oprd2 = '0; option = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; oprd1_8 = '0; oprd2_8 = '0; option8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_hi_zero_div0", {hi, 30'd0, zero, div0}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do32(4'h2, 32'hFFFFFFFF, 32'd1, r, h, z, dz, lat, rl);
    check("add_lat", 64'(lat), 64'd0);
    check("add_result", 64'(r), 64'd0);
    check("add_zero", 64'(z), 64'd1);
    check("add_after_rdy", {62'd0, in_ready, out_valid}, 64'd2);

    do32(4'h8, 32'hFFFFFFFF, 32'd2, r, h, z, dz, lat, rl);
    check("mul_lat", 64'(lat), 64'd32);
    check("mul_lo", 64'(r), 64'hFFFFFFFE);
    check("mul_hi", 64'(h), 64'h1);
    check("mul_in_ready_low", 64'(rl), 64'd1);
    check("mul_div0", 64'(dz), 64'd0);

    do32(4'h9, 32'd100, 32'd7, r, h, z, dz, lat, rl);
    check("div_lat", 64'(lat), 64'd32);
    check("div_q", 64'(r), 64'd14);
    check("div_rem", 64'(h), 64'd2);
    check("div_div0", 64'(dz), 64'd0);
    do32(4'h9, 32'd5, 32'd0, r, h, z, dz, lat, rl);
    check("div0_lat", 64'(lat), 64'd32);
    check("div0_q", 64'(r), 64'hFFFFFFFF);
    check("div0_rem", 64'(h), 64'd5);
    check("div0_flag", 64'(dz), 64'd1);

    for (int i = 0; i < 13; i++) begin
      do32(t_op[i], t_a[i], t_b[i], r, h, z, dz, lat, rl);
      check($sformatf("op%0h_v%0d_result", t_op[i], i), 64'(r), 64'(t_exp[i]));
      check($sformatf("op%0h_v%0d_zero_hi", t_op[i], i), {h, 31'd0, z},
            {32'd0, 31'd0, (t_exp[i] == 32'd0)});
      check($sformatf("op%0h_v%0d_lat", t_op[i], i), 64'(lat), 64'd0);
    end

    in_valid = 1'b1; option = 4'h7; oprd1 = 32'hFFFFFFFF; oprd2 = 32'd1;
    @(posedge clk); #1;
    option = 4'hF; oprd1 = 32'd5; oprd2 = 32'd9;
    ok = 1'b1;
    repeat (5) begin
      if (!(out_valid && result == 32'd1 && !in_ready)) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("bp_held", 64'(ok), 64'd1);
    check("bp_result", 64'(result), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {62'd0, in_ready, out_valid}, 64'd2);
    check("bp_result_kept", 64'(result), 64'd1);

    in_valid = 1'b1; option = 4'h8; oprd1 = 32'd3; oprd2 = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", {result, 30'd0, in_ready, out_valid}, 64'd2);
    @(posedge clk); #1;
    check("rst_mid_edge", {result, 30'd0, in_ready, out_valid}, 64'd2);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) ok = 1'b0;
    end
    check("rst_no_late_output", 64'(ok), 64'd1);

    do8(4'hA, 8'h80, 8'd3, r8, h8, lat);
    check("w8_sra", 64'(r8), 64'hF0);
    check("w8_sra_lat", 64'(lat), 64'd0);
    do8(4'h8, 8'h10, 8'h10, r8, h8, lat);
    check("w8_mul_lo", 64'(r8), 64'h00);
    check("w8_mul_hi", 64'(h8), 64'h01);
    check("w8_mul_lat", 64'(lat), 64'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
